// File: rtl/affine_pkg.sv
`default_nettype none
// ============================================================================
// affine: shared widths, tOP control struct, opcodes and fetch/decode helpers
// Rev 1.0
// ============================================================================
package affine;

  localparam int W_INST = 26;
  localparam int W_OP   = 6;
  localparam int W_RD   = 2;
  localparam int W_RS   = 2;
  localparam int W_I1   = 8;
  localparam int W_I2   = 8;

  localparam logic [W_OP-1:0] OP_NOP  = 6'h00;
  localparam logic [W_OP-1:0] OP_ADD  = 6'h01;
  localparam logic [W_OP-1:0] OP_ADDI = 6'h02;
  localparam logic [W_OP-1:0] OP_MULI = 6'h03;
  localparam logic [W_OP-1:0] OP_MACI = 6'h04;
  localparam logic [W_OP-1:0] OP_MOV  = 6'h05;
  localparam logic [W_OP-1:0] OP_WAIT = 6'h3C;
  localparam logic [W_OP-1:0] OP_JMP  = 6'h3D;
  localparam logic [W_OP-1:0] OP_HALT = 6'h3F;

  typedef struct packed {
    logic       frac_c;
    logic       wdual;
    logic [1:0] mul_a_sel;
    logic [1:0] add_b_sel;
  } tOP;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fd_state_t;

  typedef struct packed {
    logic legal;
    tOP   op;
  } dec_t;

  // Only data opcodes are legal here; control opcodes are handled by the FSM.
  function automatic dec_t decode_op(input logic [W_OP-1:0] opcode);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (opcode)
      OP_NOP:  d.op = tOP'(6'b0_0_00_00);
      OP_ADD:  d.op = tOP'(6'b0_0_00_01);
      OP_ADDI: d.op = tOP'(6'b0_0_00_10);
      OP_MULI: d.op = tOP'(6'b1_0_01_00);
      OP_MACI: d.op = tOP'(6'b1_1_10_10);
      OP_MOV:  d.op = tOP'(6'b0_0_00_11);
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/affine_pc.sv
`default_nettype none
// ============================================================================
// affine_pc: program counter with hold, wrapping increment and load
// Rev 1.0
// ============================================================================
module affine_pc #(
  parameter int P = 5
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         inc,
  input  logic         load,
  input  logic [P-1:0] load_val,
  output logic [P-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!nReset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/affine_fetch_decode.sv
`default_nettype none
// ============================================================================
// affine_fetch_decode: fetch from synchronous ROM, decode, issue to datapath
// Rev 1.0
// ============================================================================
module affine_fetch_decode #(
  parameter int P      = 5,
  parameter int W_INST = affine::W_INST,
  parameter int W_OP   = affine::W_OP
) (
  input  logic                   clk,
  input  logic                   nReset,
  output logic [P-1:0]           imem_addr,
  input  logic [W_INST-1:0]      imem_data,
  input  logic                   in_valid,
  output affine::tOP             op,
  output logic [affine::W_RD-1:0] rd,
  output logic [affine::W_RS-1:0] rs,
  output logic [affine::W_I1-1:0] imm1,
  output logic [affine::W_I2-1:0] imm2,
  output logic                   dec_valid,
  output logic                   wait_in,
  output logic                   halted,
  output logic                   illegal
);
  import affine::*;

  logic [W_OP-1:0]   w_opcode;
  logic [W_I2-1:0]   w_i2;
  logic [W_I1-1:0]   w_i1;
  logic [W_RD-1:0]   w_rd;
  logic [W_RS-1:0]   w_rs;

  assign w_opcode = imem_data[W_INST-1 -: W_OP];
  assign w_i2     = imem_data[19:12];
  assign w_i1     = imem_data[11:4];
  assign w_rd     = imem_data[3:2];
  assign w_rs     = imem_data[1:0];

  fd_state_t r_state;
  logic      r_fv;
  logic      r_lvl;

  fd_state_t w_state_nx;
  logic      w_fv_nx;
  logic      w_lvl_nx;
  logic      w_dv_nx;
  logic      w_wait_nx;
  logic      w_halt_nx;
  logic      w_ill_nx;
  logic      w_issue;
  logic      w_pc_inc;
  logic      w_pc_load;
  dec_t      w_dec;

  affine_pc #(.P(P)) u_pc (
    .clk      (clk),
    .nReset   (nReset),
    .inc      (w_pc_inc),
    .load     (w_pc_load),
    .load_val (w_i1[P-1:0]),
    .pc       (imem_addr)
  );

  always_comb begin
    w_state_nx = r_state;
    w_fv_nx    = r_fv;
    w_lvl_nx   = r_lvl;
    w_dv_nx    = 1'b0;
    w_wait_nx  = 1'b0;
    w_halt_nx  = halted;
    w_ill_nx   = illegal;
    w_issue    = 1'b0;
    w_pc_inc   = 1'b0;
    w_pc_load  = 1'b0;
    w_dec      = decode_op(w_opcode);
    case (r_state)
      FILL: begin
        w_pc_inc   = 1'b1;
        w_fv_nx    = 1'b1;
        w_state_nx = RUN;
      end
      RUN: begin
        if (!r_fv) begin
          // Squashed slot after a taken jump: refill from the new target.
          w_pc_inc = 1'b1;
          w_fv_nx  = 1'b1;
        end else begin
          case (w_opcode)
            OP_JMP: begin
              w_pc_load = 1'b1;
              w_fv_nx   = 1'b0;
            end
            OP_WAIT: begin
              w_state_nx = WAIT;
              w_lvl_nx   = w_i1[0];
              w_wait_nx  = 1'b1;
            end
            OP_HALT: begin
              w_state_nx = HALT;
              w_halt_nx  = 1'b1;
            end
            default: begin
              w_pc_inc = 1'b1;
              if (w_dec.legal) begin
                w_issue = 1'b1;
                w_dv_nx = 1'b1;
              end else begin
                w_ill_nx = 1'b1;
              end
            end
          endcase
        end
      end
      WAIT: begin
        // The held pc keeps the ROM presenting the word after the WAIT.
        if (in_valid == r_lvl) begin
          w_state_nx = RUN;
          w_pc_inc   = 1'b1;
          w_fv_nx    = 1'b1;
        end else begin
          w_wait_nx = 1'b1;
        end
      end
      HALT: begin
        w_halt_nx = 1'b1;
      end
      default: begin
        w_state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state   <= FILL;
      r_fv      <= 1'b0;
      r_lvl     <= 1'b0;
      dec_valid <= 1'b0;
      wait_in   <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      op        <= '0;
      rd        <= '0;
      rs        <= '0;
      imm1      <= '0;
      imm2      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_fv      <= w_fv_nx;
      r_lvl     <= w_lvl_nx;
      dec_valid <= w_dv_nx;
      wait_in   <= w_wait_nx;
      halted    <= w_halt_nx;
      illegal   <= w_ill_nx;
      if (w_issue) begin
        op   <= w_dec.op;
        rd   <= w_rd;
        rs   <= w_rs;
        imm1 <= w_i1;
        imm2 <= w_i2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_affine_fetch_decode.sv
`default_nettype none
// ============================================================================
// tb_affine_fetch_decode: directed vectors against a behavioural 1-cycle ROM
// Rev 1.0
// ============================================================================
module tb_affine_fetch_decode;
  import affine::*;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  imem_addr;
  logic [25:0] imem_data;
  tOP          op;
  logic [5:0]  op_v;
  logic [1:0]  rd, rs;
  logic [7:0]  imm1, imm2;
  logic        dec_valid, wait_in, halted, illegal;
  logic [25:0] mem [32];
  int          n_vec = 0;
  int          n_bad = 0;
  int          wait_cnt;

  assign op_v = op;

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_data <= mem[imem_addr];

  affine_fetch_decode #(.P(5)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .in_valid  (in_valid),
    .op        (op),
    .rd        (rd),
    .rs        (rs),
    .imm1      (imm1),
    .imm2      (imm2),
    .dec_valid (dec_valid),
    .wait_in   (wait_in),
    .halted    (halted),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] enc(input logic [5:0] o, input logic [7:0] i2,
                                      input logic [7:0] i1, input logic [1:0] d,
                                      input logic [1:0] s);
    return {o, i2, i1, d, s};
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 32; i++) mem[i] = enc(6'h00, 8'h00, 8'h00, 2'd0, 2'd0);
  endtask

  task automatic hold_reset();
    nReset = 1'b0;
    tick();
    tick();
  endtask

  task automatic prog_basic();
    fill_nop();
    mem[0] = enc(6'h02, 8'h00, 8'h20, 2'd1, 2'd0);
    mem[1] = enc(6'h03, 8'h00, 8'h40, 2'd2, 2'd0);
    mem[2] = enc(6'h3F, 8'h00, 8'h00, 2'd0, 2'd0);
  endtask

  task automatic prog_wait();
    fill_nop();
    mem[0] = enc(6'h02, 8'h00, 8'h01, 2'd1, 2'd0);
    mem[1] = enc(6'h3C, 8'h00, 8'h01, 2'd0, 2'd0);
    mem[2] = enc(6'h05, 8'h00, 8'h33, 2'd3, 2'd0);
    mem[3] = enc(6'h3F, 8'h00, 8'h00, 2'd0, 2'd0);
  endtask

  initial begin
    // Basic issue then HALT
    prog_basic();
    hold_reset();
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_dv", 32'(dec_valid), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);
    check("rst_wait", 32'(wait_in), 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    check("rst_op", 32'(op_v), 32'd0);
    nReset = 1'b1;
    tick();
    check("e1_addr", 32'(imem_addr), 32'd1);
    check("e1_dv", 32'(dec_valid), 32'd0);
    tick();
    check("e2_dv", 32'(dec_valid), 32'd1);
    check("e2_op", 32'(op_v), 32'b000010);
    check("e2_rd", 32'(rd), 32'd1);
    check("e2_imm1", 32'(imm1), 32'h20);
    tick();
    check("e3_op", 32'(op_v), 32'b100100);
    check("e3_imm1", 32'(imm1), 32'h40);
    check("e3_rd", 32'(rd), 32'd2);
    tick();
    check("e4_halt", 32'(halted), 32'd1);
    check("e4_dv", 32'(dec_valid), 32'd0);
    tick();
    tick();
    check("halt_hold", 32'(halted), 32'd1);
    check("halt_addr", 32'(imem_addr), 32'd3);
    // Reset during HALT
    nReset = 1'b0;
    tick();
    check("rsthalt_halt", 32'(halted), 32'd0);
    check("rsthalt_op", 32'(op_v), 32'd0);
    check("rsthalt_imm1", 32'(imm1), 32'd0);

    // Taken JMP: two bubbles, ADD behind it never issued
    fill_nop();
    mem[0] = enc(6'h02, 8'h00, 8'h11, 2'd1, 2'd0);
    mem[1] = enc(6'h02, 8'h00, 8'h22, 2'd2, 2'd0);
    mem[2] = enc(6'h3D, 8'h00, 8'h00, 2'd0, 2'd0);
    mem[3] = enc(6'h01, 8'h00, 8'h00, 2'd3, 2'd1);
    hold_reset();
    nReset = 1'b1;
    tick();
    tick();
    tick();
    check("jmp_pre_imm1", 32'(imm1), 32'h22);
    tick();
    check("jmp_b1_dv", 32'(dec_valid), 32'd0);
    check("jmp_b1_addr", 32'(imem_addr), 32'd0);
    tick();
    check("jmp_b2_dv", 32'(dec_valid), 32'd0);
    check("jmp_b2_op", 32'(op_v), 32'b000010);
    tick();
    check("jmp_tgt_dv", 32'(dec_valid), 32'd1);
    check("jmp_tgt_imm1", 32'(imm1), 32'h11);
    check("jmp_tgt_op", 32'(op_v), 32'b000010);

    // WAIT on level 1 with a 5-cycle low input
    prog_wait();
    in_valid = 1'b0;
    hold_reset();
    nReset = 1'b1;
    tick();
    tick();
    tick();
    check("w1_wait", 32'(wait_in), 32'd1);
    check("w1_dv", 32'(dec_valid), 32'd0);
    wait_cnt = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wait_in) wait_cnt++;
    end
    check("w1_addr", 32'(imem_addr), 32'd2);
    in_valid = 1'b1;
    tick();
    check("w1_exit", 32'(wait_in), 32'd0);
    check("w1_cnt", 32'(wait_cnt), 32'd6);
    check("w1_addr2", 32'(imem_addr), 32'd3);
    in_valid = 1'b0;
    tick();
    check("w1_iss_dv", 32'(dec_valid), 32'd1);
    check("w1_iss_op", 32'(op_v), 32'b000011);
    check("w1_iss_rd", 32'(rd), 32'd3);
    check("w1_iss_imm1", 32'(imm1), 32'h33);

    // Minimum one-cycle WAIT, then an undefined opcode
    fill_nop();
    mem[0] = enc(6'h3C, 8'h00, 8'h00, 2'd0, 2'd0);
    mem[1] = enc(6'h2A, 8'h00, 8'h77, 2'd1, 2'd1);
    mem[2] = enc(6'h02, 8'h00, 8'h5A, 2'd2, 2'd0);
    mem[3] = enc(6'h3F, 8'h00, 8'h00, 2'd0, 2'd0);
    in_valid = 1'b0;
    hold_reset();
    nReset = 1'b1;
    tick();
    tick();
    check("w0_wait", 32'(wait_in), 32'd1);
    check("w0_addr", 32'(imem_addr), 32'd1);
    tick();
    check("w0_exit", 32'(wait_in), 32'd0);
    check("w0_addr2", 32'(imem_addr), 32'd2);
    check("w0_ill_pre", 32'(illegal), 32'd0);
    tick();
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_dv", 32'(dec_valid), 32'd0);
    check("ill_addr", 32'(imem_addr), 32'd3);
    tick();
    check("ill_next_dv", 32'(dec_valid), 32'd1);
    check("ill_next_imm1", 32'(imm1), 32'h5A);
    check("ill_sticky", 32'(illegal), 32'd1);

    // 32 NOPs: pc wraps at 2^P
    fill_nop();
    hold_reset();
    nReset = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    check("wrap_31", 32'(imem_addr), 32'd31);
    tick();
    check("wrap_0", 32'(imem_addr), 32'd0);
    check("wrap_dv", 32'(dec_valid), 32'd1);
    check("wrap_op", 32'(op_v), 32'd0);

    // Reset asserted mid-WAIT
    prog_wait();
    in_valid = 1'b0;
    hold_reset();
    nReset = 1'b1;
    tick();
    tick();
    tick();
    check("rw_wait", 32'(wait_in), 32'd1);
    nReset = 1'b0;
    tick();
    check("rw_wait_clr", 32'(wait_in), 32'd0);
    check("rw_addr", 32'(imem_addr), 32'd0);
    check("rw_dv", 32'(dec_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
